// File: rtl/sprite_compositor.sv
// ---------------------------------------------------------------------------
// sprite_compositor
//   Composites N_SPRITES square sprites over the maze bitmap for the VGA scan.
//   Sprite positions, enables and colours are latched once per frame on
//   frame_start, so a sprite never tears mid-scan. Priority is resolved in a
//   registered 2-stage pipeline: rgb follows x/y by exactly two clocks.
//   Sprite 0 (pacman) has the highest priority.
//
//   Optional feature macro: COLLISION_EN
//     defined   : per-frame pacman-vs-sprite overlap flags are accumulated
//                 and reported on every frame_start.
//     undefined : collision and collision_valid are tied to 0.
//
// Ports
//   clk             system clock
//   reset           asynchronous, active-high reset
//   x, y            current scan position (screen coordinates)
//   frame_start     one-cycle pulse at start of frame
//   sprite_x/y      packed sprite centres, map coordinates
//   sprite_en       per-sprite visible enable
//   sprite_color    packed sprite colours
//   map_x, map_y    map coordinates of the scan position, to the map ROM
//   map_pixel       map ROM result for map_x/map_y, same cycle
//   rgb             composited colour
//   collision       per-frame overlap flags (bit 0 always 0)
//   collision_valid one-cycle pulse when collision updates
// ---------------------------------------------------------------------------
module sprite_compositor #(
  parameter int N_SPRITES = 4,
  parameter int SPRITE_W  = 24,
  parameter int POS_W     = 9,
  parameter int MAP_LU_X  = 150,
  parameter int MAP_LU_Y  = 50,
  parameter int MAP_W     = 347,
  parameter int MAP_H     = 405,
  parameter int COLOR_W   = 8,
  parameter logic [COLOR_W-1:0] COLOR_WALL = 8'b11010000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [10:0]                    x,
  input  logic [10:0]                    y,
  input  logic                           frame_start,
  input  logic [N_SPRITES*POS_W-1:0]     sprite_x,
  input  logic [N_SPRITES*POS_W-1:0]     sprite_y,
  input  logic [N_SPRITES-1:0]           sprite_en,
  input  logic [N_SPRITES*COLOR_W-1:0]   sprite_color,
  output logic [POS_W-1:0]               map_x,
  output logic [POS_W-1:0]               map_y,
  input  logic [1:0]                     map_pixel,
  output logic [COLOR_W-1:0]             rgb,
  output logic [N_SPRITES-1:0]           collision,
  output logic                           collision_valid
);

  localparam int SW = POS_W + 2;  // signed width for clipping-safe compares

  localparam logic [10:0] X_LO  = 11'(MAP_LU_X);
  localparam logic [10:0] X_HI  = 11'(MAP_LU_X + MAP_W);
  localparam logic [10:0] Y_LO  = 11'(MAP_LU_Y);
  localparam logic [10:0] Y_HI  = 11'(MAP_LU_Y + MAP_H);
  localparam logic [10:0] SCR_W = 11'd640;
  localparam logic [10:0] SCR_H = 11'd480;
  localparam logic signed [SW-1:0] HALF = SW'(SPRITE_W / 2);

  // Map coordinates are a plain offset of the scan position.
  assign map_x = POS_W'(x - X_LO);
  assign map_y = POS_W'(y - Y_LO);

  // ---------------- frame shadows ----------------
  logic [N_SPRITES*POS_W-1:0]   sh_x, sh_y;
  logic [N_SPRITES-1:0]         sh_en;
  logic [N_SPRITES*COLOR_W-1:0] sh_col;

  // NOTE: the shadows are reset (not left uninitialised) so that, before the
  // first frame_start, no sprite can render from power-up garbage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_x   <= '0;
      sh_y   <= '0;
      sh_en  <= '0;
      sh_col <= '0;
    end else if (frame_start) begin
      // NOTE: non-blocking assignments: every register samples pre-edge values.
      sh_x   <= sprite_x;
      sh_y   <= sprite_y;
      sh_en  <= sprite_en;
      sh_col <= sprite_color;
    end
  end

  // ---------------- stage 1: hit detection ----------------
  logic                 in_map;
  logic [N_SPRITES-1:0] hit;
  logic signed [SW-1:0] mx, my, sx, sy;

  always_comb begin
    // NOTE: every variable gets a default first so no latch is inferred.
    in_map = (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI) &&
             (x < SCR_W) && (y < SCR_H);
    mx  = $signed({2'b00, map_x});
    my  = $signed({2'b00, map_y});
    sx  = '0;
    sy  = '0;
    hit = '0;
    for (int i = 0; i < N_SPRITES; i++) begin
      sx = $signed({2'b00, sh_x[i*POS_W +: POS_W]});
      sy = $signed({2'b00, sh_y[i*POS_W +: POS_W]});
      // Signed window: a sprite centred near 0 yields a negative lower edge
      // instead of wrapping to the far side of the map.
      hit[i] = sh_en[i] && in_map &&
               (mx >= sx - HALF) && (mx < sx + HALF) &&
               (my >= sy - HALF) && (my < sy + HALF);
    end
  end

  logic [N_SPRITES-1:0] hit_q;
  logic                 in_map_q;
  logic [1:0]           pix_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q    <= '0;
      in_map_q <= 1'b0;
      pix_q    <= 2'b00;
    end else begin
      hit_q    <= hit;
      in_map_q <= in_map;
      pix_q    <= map_pixel;
    end
  end

  // ---------------- stage 2: priority select ----------------
  logic [COLOR_W-1:0] rgb_d;

  always_comb begin
    rgb_d = '0;
    if (in_map_q) begin
      if (|hit_q) begin
        // Descending scan so the lowest set index wins.
        for (int i = N_SPRITES - 1; i >= 0; i--)
          if (hit_q[i]) rgb_d = sh_col[i*COLOR_W +: COLOR_W];
      end else if (pix_q == 2'b00) begin
        rgb_d = COLOR_WALL;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rgb <= '0;
    else       rgb <= rgb_d;
  end

  // ---------------- collision accumulation ----------------
`ifdef COLLISION_EN
  logic [N_SPRITES-1:0] sticky, sticky_nxt;

  // Bit 0 is never set: pacman does not collide with itself.
  always_comb begin
    sticky_nxt = sticky;
    for (int k = 1; k < N_SPRITES; k++)
      if (hit_q[0] && hit_q[k]) sticky_nxt[k] = 1'b1;
  end

  // The report includes a hit registered on the frame_start cycle itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky          <= '0;
      collision       <= '0;
      collision_valid <= 1'b0;
    end else if (frame_start) begin
      collision       <= sticky_nxt;
      collision_valid <= 1'b1;
      sticky          <= '0;
    end else begin
      collision_valid <= 1'b0;
      sticky          <= sticky_nxt;
    end
  end
`else
  assign collision       = '0;
  assign collision_valid = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// ---------------------------------------------------------------------------
// tb_sprite_compositor
//   Scoreboard bench: every driven pixel pushes its expected colour, derived
//   from a behavioural model of the frame shadows, and the entry is popped
//   two clocks later when the DUT presents it. Frame reports are scored the
//   same way one clock after each frame_start.
// ---------------------------------------------------------------------------
module tb_sprite_compositor;

  localparam int N  = 4;
  localparam int PW = 9;
  localparam int CW = 8;
  localparam logic [CW-1:0] WALL = 8'b11010000;

  logic            clk = 1'b0;
  logic            reset;
  logic [10:0]     x, y;
  logic            frame_start;
  logic [N*PW-1:0] sprite_x, sprite_y;
  logic [N-1:0]    sprite_en;
  logic [N*CW-1:0] sprite_color;
  logic [PW-1:0]   map_x, map_y;
  logic [1:0]      map_pixel;
  logic [CW-1:0]   rgb;
  logic [N-1:0]    collision;
  logic            collision_valid;

  sprite_compositor dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .frame_start(frame_start),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_en(sprite_en),
    .sprite_color(sprite_color), .map_x(map_x), .map_y(map_y),
    .map_pixel(map_pixel), .rgb(rgb), .collision(collision),
    .collision_valid(collision_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1);
  end

  // ---------------- model state ----------------
  int          m_sx [N];
  int          m_sy [N];
  bit          m_en [N];
  logic [7:0]  m_col[N];
  logic [N-1:0] m_pend, m_sticky;

  typedef struct {
    bit         chk;
    logic [7:0] exp;
    int         id;
  } px_t;

  px_t          px_q[$];
  logic [N-1:0] col_q[$];
  int checks = 0;
  int errors = 0;
  int px_id  = 0;

  function automatic bit m_in_map(int px, int py);
    return px >= 150 && px < 497 && py >= 50 && py < 455 && px < 640 && py < 480;
  endfunction

  function automatic logic [N-1:0] m_hits(int px, int py);
    logic [N-1:0] h = '0;
    int mx = px - 150;
    int my = py - 50;
    if (m_in_map(px, py))
      for (int i = 0; i < N; i++)
        if (m_en[i] && mx >= m_sx[i] - 12 && mx < m_sx[i] + 12 &&
            my >= m_sy[i] - 12 && my < m_sy[i] + 12)
          h[i] = 1'b1;
    return h;
  endfunction

  function automatic logic [7:0] m_rgb(int px, int py, logic [1:0] mp);
    logic [N-1:0] h = m_hits(px, py);
    if (!m_in_map(px, py)) return 8'h00;
    for (int i = 0; i < N; i++)
      if (h[i]) return m_col[i];
    return (mp == 2'b00) ? WALL : 8'h00;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_sx[i] = 0; m_sy[i] = 0; m_en[i] = 1'b0; m_col[i] = 8'h00;
    end
    m_pend   = '0;
    m_sticky = '0;
    px_q.delete();
    col_q.delete();
  endtask

  task automatic set_sprite(int i, int sx, int sy, logic [7:0] c);
    sprite_x[i*PW +: PW]     = PW'(sx);
    sprite_y[i*PW +: PW]     = PW'(sy);
    sprite_color[i*CW +: CW] = c;
  endtask

  // One pixel clock: score what the DUT shows now, then drive the next pixel.
  task automatic step(int px, int py, logic [1:0] mp, bit fs);
    px_t          e;
    logic [N-1:0] h, ev;
    @(negedge clk);
    if (px_q.size() == 2) begin
      e = px_q.pop_front();
      if (e.chk) begin
        checks++;
        if (rgb !== e.exp) begin
          errors++;
          $display("FAIL rgb pixel %0d: got %h expected %h", e.id, rgb, e.exp);
        end
      end
    end
`ifdef COLLISION_EN
    checks++;
    if (col_q.size() > 0) begin
      ev = col_q.pop_front();
      if (collision_valid !== 1'b1 || collision !== ev) begin
        errors++;
        $display("FAIL collision report: got valid=%b flags=%b expected valid=1 flags=%b",
                 collision_valid, collision, ev);
      end
    end else if (collision_valid !== 1'b0) begin
      errors++;
      $display("FAIL collision_valid idle: got %b expected 0", collision_valid);
    end
`else
    checks++;
    if (collision !== '0 || collision_valid !== 1'b0) begin
      errors++;
      $display("FAIL collision disabled: got valid=%b flags=%b expected 0/0000",
               collision_valid, collision);
    end
`endif
    x = 11'(px); y = 11'(py); map_pixel = mp; frame_start = fs;
    h = m_hits(px, py);
    // A pixel driven with frame_start is rendered across the shadow update.
    e.chk = !fs;
    e.exp = m_rgb(px, py, mp);
    e.id  = px_id++;
    px_q.push_back(e);
    if (fs) begin
`ifdef COLLISION_EN
      col_q.push_back(m_sticky | m_pend);
`endif
      m_sticky = '0;
      for (int i = 0; i < N; i++) begin
        m_sx[i]  = int'(sprite_x[i*PW +: PW]);
        m_sy[i]  = int'(sprite_y[i*PW +: PW]);
        m_en[i]  = sprite_en[i];
        m_col[i] = sprite_color[i*CW +: CW];
      end
    end else begin
      m_sticky = m_sticky | m_pend;
    end
    m_pend = '0;
    for (int k = 1; k < N; k++) m_pend[k] = h[0] & h[k];
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; x = '0; y = '0; frame_start = 1'b0; map_pixel = 2'b00;
    sprite_x = '0; sprite_y = '0; sprite_en = '0; sprite_color = '0;
    model_clear();
    #1;
    checks++;
    if (rgb !== '0 || collision !== '0 || collision_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset outputs: got rgb=%h col=%b valid=%b expected 0",
               rgb, collision, collision_valid);
    end
    x = 11'd238; y = 11'd138;
    #1;
    checks++;
    if (map_x !== 9'd88 || map_y !== 9'd88) begin
      errors++;
      $display("FAIL map coords: got %0d,%0d expected 88,88", map_x, map_y);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_no_frame();
    set_sprite(0, 100, 100, 8'h3F);
    sprite_en = 4'b0001;
    step(238, 138, 2'b00, 0);   // no frame_start yet: walls only
    step(238, 138, 2'b01, 0);
    step(300, 200, 2'b00, 0);
  endtask

  task automatic test_single_sprite();
    set_sprite(0, 100, 100, 8'h3F);
    sprite_en = 4'b0001;
    step(0, 0, 2'b01, 1);
    step(238, 138, 2'b01, 0);   // map (88,88): first sprite pixel
    step(262, 138, 2'b00, 0);   // map 112: just outside, wall
    step(262, 138, 2'b01, 0);   // outside, floor
    step(261, 161, 2'b01, 0);   // map (111,111): last sprite pixel
    step(237, 138, 2'b00, 0);   // map 87: just outside
  endtask

  task automatic test_priority();
    set_sprite(0, 60, 60, 8'h3F);
    set_sprite(1, 60, 60, 8'h77);
    sprite_en = 4'b0011;
    step(0, 0, 2'b01, 1);
    step(210, 110, 2'b01, 0);
    step(215, 115, 2'b00, 0);
    sprite_en = 4'b0010;
    step(0, 0, 2'b01, 1);
    step(210, 110, 2'b01, 0);
    step(215, 115, 2'b00, 0);
  endtask

  task automatic test_clip();
    set_sprite(2, 5, 5, 8'h55);
    set_sprite(3, 500, 10, 8'h0C);
    sprite_en = 4'b1100;
    step(0, 0, 2'b01, 1);
    step(150, 50, 2'b01, 0);    // map (0,0) is inside the clipped sprite
    step(149, 50, 2'b00, 0);    // left of the map: black
    step(150, 49, 2'b00, 0);    // above the map: black
    step(496, 60, 2'b01, 0);    // last map column, sprite 3 not reached
    step(497, 60, 2'b00, 0);    // right of the map: black
    step(166, 66, 2'b01, 0);    // map (16,16): last pixel of sprite 2
    step(167, 66, 2'b01, 0);    // map 17: outside
  endtask

  task automatic test_mid_frame();
    set_sprite(0, 100, 100, 8'h3F);
    sprite_en = 4'b0001;
    step(0, 0, 2'b01, 1);
    step(238, 138, 2'b01, 0);
    sprite_x[0 +: PW] = 9'd200;   // invisible until next frame_start
    step(238, 138, 2'b01, 0);
    step(338, 138, 2'b01, 0);
    step(0, 0, 2'b01, 1);
    step(238, 138, 2'b01, 0);
    step(338, 138, 2'b01, 0);
  endtask

  task automatic test_collision();
    set_sprite(0, 100, 100, 8'h3F);
    set_sprite(3, 110, 100, 8'h0C);
    sprite_en = 4'b1001;
    step(0, 0, 2'b01, 1);
    step(255, 150, 2'b01, 0);   // map (105,100): sprites 0 and 3 overlap
    step(265, 150, 2'b01, 0);   // map 115: sprite 3 only
    step(0, 0, 2'b01, 1);       // frame N report: 1000
    step(265, 150, 2'b01, 0);
    step(238, 138, 2'b01, 0);   // sprite 0 only
    step(0, 0, 2'b01, 1);       // frame N+1 report: 0000
    step(255, 150, 2'b01, 0);   // overlap right before frame_start
    step(0, 0, 2'b01, 1);       // still counted for the closing frame
    step(255, 150, 2'b01, 1);   // overlap driven with frame_start
    step(0, 0, 2'b01, 1);       // counted toward the next frame
    step(0, 0, 2'b01, 0);
  endtask

  task automatic test_back_to_back();
    step(255, 150, 2'b01, 0);
    step(0, 0, 2'b01, 1);
    step(0, 0, 2'b01, 1);       // second report must be 0
    step(0, 0, 2'b01, 0);
  endtask

  task automatic test_reset_mid_frame();
    sprite_en = 4'b0001;
    step(0, 0, 2'b01, 1);
    step(238, 138, 2'b01, 0);
    step(240, 140, 2'b01, 0);
    step(242, 142, 2'b01, 0);   // rgb now shows 3F
    reset = 1'b1;
    #1;
    checks++;
    if (rgb !== '0 || collision !== '0 || collision_valid !== 1'b0) begin
      errors++;
      $display("FAIL async reset: got rgb=%h col=%b valid=%b expected 0",
               rgb, collision, collision_valid);
    end
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    frame_start = 1'b0;
    step(238, 138, 2'b00, 0);   // shadows cleared: wall only
    step(238, 138, 2'b01, 0);
  endtask

  initial begin
    test_reset();
    test_no_frame();
    test_single_sprite();
    test_priority();
    test_clip();
    test_mid_frame();
    test_collision();
    test_back_to_back();
    test_reset_mid_frame();
    step(0, 0, 2'b01, 0);
    step(0, 0, 2'b01, 0);
    step(0, 0, 2'b01, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
Parametrised successor to the single-pacman/three-monster renderer. Composites N_SPRITES square sprites over the maze bitmap for the VGA scan.
- Latches sprite positions once per frame, so sprites do not tear mid-scan.
- Resolves sprite priority in a registered 2-stage pipeline.
- Reports per-frame pacman-vs-sprite pixel overlap to the game logic.
- Sits between the pacman/monster movers, the mapRom lookup and the VGA output.

Parameters:
N_SPRITES, 4, number of sprites; index 0 is pacman and has the highest priority.
SPRITE_W, 24, sprite edge length in pixels (even).
POS_W, 9, width of sprite/map coordinates.
MAP_LU_X, 150, screen x of map origin.
MAP_LU_Y, 50, screen y of map origin.
MAP_W, 347, map width in pixels.
MAP_H, 405, map height in pixels.
COLOR_W, 8, colour width.
COLOR_WALL, 8'b11010000, wall colour.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
x  in  11  current scan x
y  in  11  current scan y
frame_start  in  1  one-cycle pulse at start of frame
sprite_x  in  N_SPRITES*POS_W  packed sprite centre x, map coordinates
sprite_y  in  N_SPRITES*POS_W  packed sprite centre y
sprite_en  in  N_SPRITES  per-sprite visible enable
sprite_color  in  N_SPRITES*COLOR_W  packed sprite colours
map_x  out  POS_W  x-MAP_LU_X, combinational, to map ROM
map_y  out  POS_W  y-MAP_LU_Y, combinational
map_pixel  in  2  ROM result for map_x/map_y, same cycle
rgb  out  COLOR_W  composited colour
collision  out  N_SPRITES  per-frame overlap flags; bit 0 always 0
collision_valid  out  1  one-cycle pulse when collision updates

Behaviour:
- Reset (async, active-high) clears: latched positions, latched enables, latched colours, both pipeline stages, rgb, collision, collision_valid, sticky flags. All outputs read 0.
- Frame latch: on the clk edge with frame_start=1, copy sprite_x/y/en/color into shadow registers. Rendering uses only the shadows. Input changes mid-frame are invisible until the next frame_start.
- Stage 1 (registered):
  - in_map = x>=MAP_LU_X, x<MAP_LU_X+MAP_W, y>=MAP_LU_Y, y<MAP_LU_Y+MAP_H, and x<640, y<480.
  - hit[i] = shadow_en[i] and in_map and map_x in [sx-SPRITE_W/2, sx+SPRITE_W/2) and map_y in [sy-SPRITE_W/2, sy+SPRITE_W/2).
  - Hit compares use signed POS_W+2 arithmetic, so sprites near coordinate 0 clip correctly with no wrap-around.
  - Registers: hit vector, in_map, map_pixel.
- Stage 2 (registered), selects rgb in this order:
  - not in_map: 0.
  - otherwise lowest-index set hit bit: that sprite's shadow colour.
  - otherwise map_pixel==2'b00: COLOR_WALL.
  - otherwise: 0.
- Latency: rgb corresponds to x/y presented exactly 2 clocks earlier. One pixel per clock, no stalls.
- Collision accumulation:
  - sticky[k] (k>=1) is set when the stage-1 register shows hit[0] and hit[k] together.
  - On frame_start: collision <= sticky (including any set this same cycle), collision_valid <= 1 for one cycle, sticky cleared.
  - A stage-1 hit registered on the frame_start cycle counts toward the closing frame.
  - frame_start pulses on consecutive cycles: each one reports and clears; the second reports 0.
- No frame_start ever received: collision stays 0 and shadows stay at reset values, so nothing renders except walls.
- N_SPRITES=1: collision is constant 0; collision_valid still pulses.

Optional Feature:
COLLISION_EN
- Defined: sticky and collision logic as above.
- Undefined: no sticky registers; collision tied to 0 and collision_valid tied to 0. Rendering is unchanged.

Test Plan:
- Reset mid-frame while rgb is non-zero -> rgb, collision and collision_valid read 0 immediately, before the next clk edge.
- frame_start with sprite0=(100,100), en=0001, colour 8'h3F; scan x=150+88, y=50+88 -> rgb=8'h3F two clocks later. At x=150+112 -> not a sprite pixel (rgb=COLOR_WALL if map_pixel=00, else 0).
- Sprites 0 and 1 both at (60,60), colours 8'h3F and 8'h77 -> overlap pixel renders 8'h3F. With en=0010 it renders 8'h77.
- Sprite 2 at (5,5): pixel map(0,0) is hit, screen x=149 -> rgb=0. No wrap artefacts at map x=500+.
- sprite_x changed mid-frame -> output unchanged until after the next frame_start.
- Sprites 0 and 3 overlap during frame N -> at frame N+1 start collision=4'b1000 with a one-cycle collision_valid. With no overlap in frame N+1, the next report is 4'b0000. With COLLISION_EN undefined, both outputs stay 0.
